// File: rtl/flux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : flux_scheduler
//  Description : Round-robin scheduler. It shares one downstream actor between
//                FLUX input FIFO channels. Each grant serves up to QUANTUM
//                tokens. Every token is forwarded with its flux index as a tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module flux_scheduler #(
    parameter int FLUX       = 2,
    parameter int DATA_WIDTH = 8,
    parameter int QUANTUM    = 4,
    parameter int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX-1:0]                 in_empty,
    output logic [FLUX-1:0]                 in_read,
    input  logic [DATA_WIDTH-1:0]           in_dout,
    input  logic                            out_full,
    output logic                            out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
    output logic [TAG_WIDTH-1:0]            grant_tag,
    output logic                            grant_valid
);

    localparam int c_CNT_WIDTH  = $clog2(QUANTUM + 1);
    // One extra bit so (last + 1 + i) never overflows before the explicit wrap.
    localparam int c_CAND_WIDTH = TAG_WIDTH + 1;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SERVE = 1'b1;

    localparam logic [c_CNT_WIDTH-1:0]  c_LAST_CNT   = c_CNT_WIDTH'(QUANTUM - 1);
    localparam logic [TAG_WIDTH-1:0]    c_LAST_RESET = TAG_WIDTH'(FLUX - 1);
    localparam logic [c_CAND_WIDTH-1:0] c_FLUX       = c_CAND_WIDTH'(FLUX);

    logic [0:0]              r_state;
    logic [TAG_WIDTH-1:0]    r_tag;
    logic [TAG_WIDTH-1:0]    r_last;
    logic [c_CNT_WIDTH-1:0]  r_count;

    logic                    w_found;
    logic [TAG_WIDTH-1:0]    w_pick;
    logic [c_CAND_WIDTH-1:0] w_cand;
    logic [TAG_WIDTH-1:0]    w_idx;
    logic                    w_xfer;
    logic                    w_exit;
    logic [FLUX-1:0]         w_read;

    // Round-robin search starting after the last served flux, wrapping modulo FLUX.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        w_idx   = '0;
        for (int i = 0; i < FLUX; i++) begin
            w_cand = {1'b0, r_last} + c_CAND_WIDTH'(i) + c_CAND_WIDTH'(1);
            if (w_cand >= c_FLUX) begin
                w_cand = w_cand - c_FLUX;
            end
            w_idx = w_cand[TAG_WIDTH-1:0];
            if (!w_found && !in_empty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign grant_valid = (r_state == c_SERVE);
    assign grant_tag   = r_tag;
    assign w_xfer      = grant_valid && !in_empty[r_tag] && !out_full;
    // An empty granted FIFO ends the burst even while the output is stalled.
    assign w_exit      = (w_xfer && (r_count == c_LAST_CNT)) || in_empty[r_tag];

    // Read strobe goes only to the granted flux, and only on a transfer.
    always_comb begin
        w_read = '0;
        if (w_xfer) begin
            w_read[r_tag] = 1'b1;
        end
    end

    assign in_read   = w_read;
    assign out_write = w_xfer;
    assign out_din   = {r_tag, in_dout};

    // Grant state machine: IDLE arbitrates, SERVE streams one burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_tag   <= '0;
            r_last  <= c_LAST_RESET;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_tag   <= w_pick;
                        r_count <= '0;
                        r_state <= c_SERVE;
                    end
                end
                c_SERVE: begin
                    if (w_xfer) begin
                        r_count <= r_count + c_CNT_WIDTH'(1);
                    end
                    if (w_exit) begin
                        r_last  <= r_tag;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flux_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flux_scheduler
//  Description : Directed self-checking bench for flux_scheduler. It uses a
//                two-flux instance and a three-flux instance, each fed by a
//                behavioural FIFO model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flux_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-flux instance (QUANTUM = 4)
    logic [1:0] in_empty, in_read;
    logic [7:0] in_dout;
    logic       out_full, out_write;
    logic [8:0] out_din;
    logic [0:0] grant_tag;
    logic       grant_valid;
    int         avail [2];
    int         idx   [2];

    // Three-flux instance (QUANTUM = 4)
    logic [2:0] in_empty3, in_read3;
    logic [7:0] in_dout3;
    logic       out_full3, out_write3;
    logic [9:0] out_din3;
    logic [1:0] grant_tag3;
    logic       grant_valid3;
    int         avail3 [3];
    int         idx3   [3];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [7:0] tok(input logic [7:0] base, input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return base + kk;
    endfunction

    assign in_empty  = {avail[1] == 0, avail[0] == 0};
    assign in_dout   = in_read[1] ? tok(8'hA1, idx[1]) : tok(8'h01, idx[0]);
    assign in_empty3 = {avail3[2] == 0, avail3[1] == 0, avail3[0] == 0};
    assign in_dout3  = in_read3[2] ? tok(8'hC1, idx3[2]) :
                       in_read3[1] ? tok(8'hB1, idx3[1]) : tok(8'h01, idx3[0]);

    flux_scheduler #(.FLUX(2), .DATA_WIDTH(8), .QUANTUM(4)) dut (
        .clk(clk), .rst(rst),
        .in_empty(in_empty), .in_read(in_read), .in_dout(in_dout),
        .out_full(out_full), .out_write(out_write), .out_din(out_din),
        .grant_tag(grant_tag), .grant_valid(grant_valid)
    );

    flux_scheduler #(.FLUX(3), .DATA_WIDTH(8), .QUANTUM(4)) dut3 (
        .clk(clk), .rst(rst),
        .in_empty(in_empty3), .in_read(in_read3), .in_dout(in_dout3),
        .out_full(out_full3), .out_write(out_write3), .out_din(out_din3),
        .grant_tag(grant_tag3), .grant_valid(grant_valid3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample read strobes before the edge, then pop the FIFO models.
    task automatic tick();
        logic [1:0] r2;
        logic [2:0] r3;
        #3;
        r2 = in_read;
        r3 = in_read3;
        @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) if (r2[f]) begin avail[f]--; idx[f]++; end
        for (int f = 0; f < 3; f++) if (r3[f]) begin avail3[f]--; idx3[f]++; end
        #1;
    endtask

    task automatic clear_models();
        for (int f = 0; f < 2; f++) begin avail[f] = 0; idx[f] = 0; end
        for (int f = 0; f < 3; f++) begin avail3[f] = 0; idx3[f] = 0; end
        out_full  = 1'b0;
        out_full3 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_models();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int      n;
        logic    ew;
        logic    et;
        logic [1:0] et3;

        // ---------------- Reset / single flux ----------------
        rst = 1'b1;
        clear_models();
        @(posedge clk);
        #1;
        chk("rst_grant_valid", grant_valid, 1'b0);
        chk("rst_out_write",   out_write,   1'b0);
        chk("rst_in_read",     in_read,     2'b00);
        chk("rst_grant_tag",   grant_tag,   1'b0);
        chk("rst_grant_valid3", grant_valid3, 1'b0);
        rst = 1'b0;
        avail[1] = 3;
        #1;
        chk("idle_no_strobe", {out_write, in_read}, 3'b000);
        tick();
        chk("single_grant", {grant_valid, grant_tag}, 2'b11);
        chk("single_d0", {out_write, in_read, out_din}, {1'b1, 2'b10, 9'h1A1});
        tick();
        chk("single_d1", {out_write, in_read, out_din}, {1'b1, 2'b10, 9'h1A2});
        tick();
        chk("single_d2", {out_write, in_read, out_din}, {1'b1, 2'b10, 9'h1A3});
        tick();
        chk("single_empty_hold", {out_write, in_read, grant_valid}, 4'b0001);
        tick();
        chk("single_exit", {out_write, in_read, grant_valid}, 4'b0000);
        // last is now 1, so flux 0 must win when both become non-empty
        avail[0] = 1;
        avail[1] = 1;
        tick();
        chk("single_last_rr", {grant_valid, grant_tag, in_read}, 4'b1001);

        // ---------------- Quantum rotation ----------------
        do_reset();
        avail[0] = 10;
        avail[1] = 10;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ew = ((c - 1) % 5) != 4;
            et = (((c - 1) / 5) % 2) == 1;
            chk("rot_strobe", {out_write, in_read, grant_valid},
                {ew, ew ? (et ? 2'b10 : 2'b01) : 2'b00, ew});
            if (ew) begin
                n = ((c - 1) / 10) * 4 + ((c - 1) % 5);
                chk("rot_data", out_din, {et, tok(et ? 8'hA1 : 8'h01, n)});
            end
        end

        // ---------------- Backpressure ----------------
        do_reset();
        avail[0] = 6;
        tick();
        chk("bp_d0", {out_write, in_read, out_din}, {1'b1, 2'b01, 9'h001});
        tick();
        chk("bp_d1", {out_write, in_read, out_din}, {1'b1, 2'b01, 9'h002});
        tick();
        out_full = 1'b1;
        #1;
        for (int s = 0; s < 5; s++) begin
            if (s != 0) tick();
            chk("bp_stall", {out_write, in_read, grant_valid}, 4'b0001);
            chk("bp_count", 32'(dut.r_count), 32'd2);
        end
        out_full = 1'b0;
        #1;
        chk("bp_d2", {out_write, in_read, out_din}, {1'b1, 2'b01, 9'h003});
        tick();
        chk("bp_d3", {out_write, in_read, out_din}, {1'b1, 2'b01, 9'h004});
        tick();
        chk("bp_exit", {out_write, in_read, grant_valid}, 4'b0000);
        tick();
        chk("bp_regrant0", {out_write, in_read, out_din}, {1'b1, 2'b01, 9'h005});

        // ---------------- Simultaneous exit ----------------
        do_reset();
        avail[0] = 4;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("sim_data", {out_write, in_read, out_din}, {1'b1, 2'b01, 1'b0, tok(8'h01, c)});
        end
        tick();
        chk("sim_single_idle", {out_write, in_read, grant_valid}, 4'b0000);
        avail[1] = 1;
        tick();
        chk("sim_next_flux1", {grant_valid, grant_tag, out_write, in_read, out_din},
            {1'b1, 1'b1, 1'b1, 2'b10, 9'h1A1});

        // ---------------- Async reset mid-operation ----------------
        do_reset();
        avail[1] = 3;
        tick();
        chk("ar_serve", {out_write, in_read, out_din}, {1'b1, 2'b10, 9'h1A1});
        #2;
        rst = 1'b1;
        #1;
        chk("ar_drop", {out_write, in_read, grant_valid}, 4'b0000);
        avail[0] = 2;
        #2;
        rst = 1'b0;
        tick();
        chk("ar_lowest", {grant_tag, out_write, in_read, out_din},
            {1'b0, 1'b1, 2'b01, 9'h001});

        // ---------------- FLUX=3 wrap ----------------
        do_reset();
        avail3[0] = 8;
        avail3[2] = 8;
        for (int c = 1; c <= 20; c++) begin
            tick();
            ew  = ((c - 1) % 5) != 4;
            et3 = ((((c - 1) / 5) % 2) == 1) ? 2'd2 : 2'd0;
            chk("f3_strobe", {out_write3, in_read3, grant_valid3},
                {ew, ew ? ((et3 == 2'd2) ? 3'b100 : 3'b001) : 3'b000, ew});
            if (ew) begin
                n = ((c - 1) / 10) * 4 + ((c - 1) % 5);
                chk("f3_data", {grant_tag3, out_din3},
                    {et3, et3, tok((et3 == 2'd2) ? 8'hC1 : 8'h01, n)});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
